// File: rtl/sprite_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pixel_fetch
// Purpose  : Consumer side of the sprite address interface. Picks the
//            highest-priority active layer (layer 0 = runner, lowest index
//            wins), issues one sprite-ROM read per pixel, maps the returned
//            4-bit palette index to 24-bit RGB and registers it pipeline-aligned
//            with the delayed blanking signal. Also keeps a per-frame sticky
//            runner/obstacle collision flag.
// Ports    : pixel_Clk, Reset_n (async, active low)
//            frame_start  - one-cycle pulse at first pixel of a frame
//            blank_n      - active-video qualifier (1 = visible)
//            layer_on     - per-layer hit, LAYERS bits
//            layer_addr   - packed addresses, layer k at [k*ADDR_W +: ADDR_W]
//            rom_addr/rom_rd - registered sprite-ROM read request
//            rom_q        - palette index, valid one cycle after rom_rd
//            Red/Green/Blue, pix_valid - colour output, 3-cycle latency
//            collision    - sticky runner-versus-obstacle hit
// Config   : SPRITE_FETCH_TRANSPARENT_EN - when defined, palette index 0 is
//            transparent (BG_RGB, never collides); otherwise index 0 is black
//            and collision is a bounding-box overlap test.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_pixel_fetch #(
    parameter int          LAYERS = 4,
    parameter int          ADDR_W = 18,
    parameter logic [23:0] BG_RGB = 24'hF7F7F7
) (
    input  logic                     pixel_Clk,
    input  logic                     Reset_n,
    input  logic                     frame_start,
    input  logic                     blank_n,
    input  logic [LAYERS-1:0]        layer_on,
    input  logic [LAYERS*ADDR_W-1:0] layer_addr,
    output logic [ADDR_W-1:0]        rom_addr,
    output logic                     rom_rd,
    input  logic [3:0]               rom_q,
    output logic [7:0]               Red,
    output logic [7:0]               Green,
    output logic [7:0]               Blue,
    output logic                     pix_valid,
    output logic                     collision
);

    localparam int c_SEL_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;

    // ---------------- S0: priority select ----------------
    logic                w_hit;
    logic [c_SEL_W-1:0]  w_win;
    logic [ADDR_W-1:0]   w_win_addr;

    // Walk from the lowest priority upwards so the lowest set index is the
    // last assignment and therefore wins.
    always_comb begin
        w_hit      = 1'b0;
        w_win      = '0;
        w_win_addr = '0;
        for (int k = LAYERS - 1; k >= 0; k--) begin
            if (layer_on[k]) begin
                w_hit      = 1'b1;
                w_win      = c_SEL_W'(k);
                w_win_addr = layer_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    logic               r_sel_valid;
    logic [c_SEL_W-1:0] r_sel_layer;
    logic               r_others_on;
    logic               r_blank_d1;

    always_ff @(posedge pixel_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr    <= '0;
            rom_rd      <= 1'b0;
            r_sel_valid <= 1'b0;
            r_sel_layer <= '0;
            r_others_on <= 1'b0;
            r_blank_d1  <= 1'b0;
        end else begin
            rom_rd      <= w_hit;
            r_sel_valid <= w_hit;
            r_sel_layer <= w_win;
            r_others_on <= |layer_on[LAYERS-1:1];
            r_blank_d1  <= blank_n;
            // Address holds when idle so the ROM bus does not toggle.
            if (w_hit) begin
                rom_addr <= w_win_addr;
            end
        end
    end

    // ---------------- S1: ROM data return ----------------
    // The ROM registers its output on the same edge that moves the S0
    // sideband into these registers, so rom_q and the *_d registers are
    // aligned and together form the S1 stage.
    logic               r_sel_valid_d;
    logic [c_SEL_W-1:0] r_sel_layer_d;
    logic               r_others_on_d;
    logic               r_blank_d2;

    always_ff @(posedge pixel_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sel_valid_d <= 1'b0;
            r_sel_layer_d <= '0;
            r_others_on_d <= 1'b0;
            r_blank_d2    <= 1'b0;
        end else begin
            r_sel_valid_d <= r_sel_valid;
            r_sel_layer_d <= r_sel_layer;
            r_others_on_d <= r_others_on;
            r_blank_d2    <= r_blank_d1;
        end
    end

    // Stale ROM data is masked when no read was issued for this pixel.
    logic [3:0] w_idx;
    assign w_idx = r_sel_valid_d ? rom_q : 4'd0;

    // ---------------- S2: palette ----------------
    logic [23:0] w_rgb;

    always_comb begin
        w_rgb = BG_RGB;
        if (r_sel_valid_d) begin
            case (w_idx)
`ifdef SPRITE_FETCH_TRANSPARENT_EN
                4'd0:    w_rgb = BG_RGB;
`else
                4'd0:    w_rgb = 24'h000000;
`endif
                4'd1:    w_rgb = 24'h535353;
                4'd2:    w_rgb = 24'hFFFFFF;
                4'd3:    w_rgb = 24'hACACAC;
                default: w_rgb = 24'h000000;
            endcase
        end
    end

    always_ff @(posedge pixel_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Red       <= 8'd0;
            Green     <= 8'd0;
            Blue      <= 8'd0;
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= r_blank_d2;
            if (r_blank_d2) begin
                Red   <= w_rgb[23:16];
                Green <= w_rgb[15:8];
                Blue  <= w_rgb[7:0];
            end else begin
                Red   <= 8'd0;
                Green <= 8'd0;
                Blue  <= 8'd0;
            end
        end
    end

    // ---------------- Collision ----------------
    logic w_col_set;

`ifdef SPRITE_FETCH_TRANSPARENT_EN
    assign w_col_set = r_sel_valid_d && (r_sel_layer_d == '0) && r_others_on_d
                       && r_blank_d2 && (w_idx != 4'd0);
`else
    assign w_col_set = r_sel_valid_d && (r_sel_layer_d == '0) && r_others_on_d
                       && r_blank_d2;
`endif

    // A set in the same cycle as frame_start wins so a hit on the first
    // pixel of a frame is not lost.
    always_ff @(posedge pixel_Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            collision <= 1'b0;
        end else if (w_col_set) begin
            collision <= 1'b1;
        end else if (frame_start) begin
            collision <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_pixel_fetch
// Purpose  : Scoreboard bench for sprite_pixel_fetch. The stimulus process
//            computes each pixel's expected colour from the layer inputs and a
//            bench-owned sprite ROM table, and queues it with the edge at
//            which it must appear; a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_pixel_fetch;

    localparam logic [23:0] c_BG = 24'hF7F7F7;

    logic        pixel_Clk = 1'b0;
    logic        Reset_n   = 1'b1;
    logic        frame_start = 1'b0;
    logic        blank_n   = 1'b0;
    logic [3:0]  layer_on  = 4'd0;
    logic [71:0] layer_addr = '0;
    logic [17:0] rom_addr;
    logic        rom_rd;
    logic [3:0]  rom_q = 4'd0;
    logic [7:0]  Red, Green, Blue;
    logic        pix_valid;
    logic        collision;

    sprite_pixel_fetch #(.LAYERS(4), .ADDR_W(18), .BG_RGB(c_BG)) dut (
        .pixel_Clk  (pixel_Clk),
        .Reset_n    (Reset_n),
        .frame_start(frame_start),
        .blank_n    (blank_n),
        .layer_on   (layer_on),
        .layer_addr (layer_addr),
        .rom_addr   (rom_addr),
        .rom_rd     (rom_rd),
        .rom_q      (rom_q),
        .Red        (Red),
        .Green      (Green),
        .Blue       (Blue),
        .pix_valid  (pix_valid),
        .collision  (collision)
    );

    always #5 pixel_Clk = ~pixel_Clk;

    // Sprite ROM: synchronous read, data one cycle after the request.
    logic [3:0] rom_mem [64];
    always @(posedge pixel_Clk) if (rom_rd) rom_q <= rom_mem[rom_addr[5:0]];

    int edge_cnt = 0;
    always @(posedge pixel_Clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int          due;
        logic [23:0] rgb;
        logic        vld;
        logic        cset;
    } exp_t;

    exp_t        sb[$];
    bit          exp_rd   [int];
    logic [17:0] exp_addr [int];
    bit          fs_at    [int];
    logic [17:0] m_last_addr = '0;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_cnt, act, exp);
        end
    endtask

    function automatic logic [23:0] pal(input logic [3:0] i);
        case (i)
`ifdef SPRITE_FETCH_TRANSPARENT_EN
            4'd0: return c_BG;
`else
            4'd0: return 24'h000000;
`endif
            4'd1: return 24'h535353;
            4'd2: return 24'hFFFFFF;
            4'd3: return 24'hACACAC;
            default: return 24'h000000;
        endcase
    endfunction

    // Called just after a posedge: drives the inputs sampled at the next edge
    // and queues what the DUT must show for them.
    task automatic step(input logic [3:0] on, input logic [17:0] a0, input logic [17:0] a1,
                        input logic [17:0] a2, input logic [17:0] a3,
                        input logic bl, input logic fs);
        exp_t        it;
        int          win;
        logic [17:0] a [4];
        logic [3:0]  idx;
        logic [23:0] rgb;
        a = '{a0, a1, a2, a3};
        layer_on    = on;
        layer_addr  = {a3, a2, a1, a0};
        blank_n     = bl;
        frame_start = fs;
        win = -1;
        for (int k = 3; k >= 0; k--) if (on[k]) win = k;
        if (win < 0) begin
            idx = 4'd0;
            rgb = c_BG;
        end else begin
            m_last_addr = a[win];
            idx = rom_mem[a[win][5:0]];
            rgb = pal(idx);
        end
        exp_rd[edge_cnt + 1]   = (win >= 0);
        exp_addr[edge_cnt + 1] = m_last_addr;
        fs_at[edge_cnt + 1]    = fs;
        it.due = edge_cnt + 3;
        it.vld = bl;
        it.rgb = bl ? rgb : 24'h000000;
`ifdef SPRITE_FETCH_TRANSPARENT_EN
        it.cset = bl && (win == 0) && (on[3:1] != 3'b000) && (idx != 4'd0);
`else
        it.cset = bl && (win == 0) && (on[3:1] != 3'b000);
`endif
        sb.push_back(it);
        @(posedge pixel_Clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        Reset_n = 1'b0;
        sb.delete();
        exp_rd.delete();
        exp_addr.delete();
        fs_at.delete();
        m_last_addr = '0;
        repeat (cycles) @(posedge pixel_Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    // Monitor
    logic exp_col = 1'b0;
    always @(negedge pixel_Clk) begin
        exp_t        it;
        bit          got;
        int          e;
        logic [23:0] ergb;
        logic        evld;
        if (started) begin
            if (!Reset_n) begin
                exp_col = 1'b0;
                check("reset_rgb", {8'd0, Red, Green, Blue}, 32'd0);
                check("reset_valid", {31'd0, pix_valid}, 32'd0);
                check("reset_rd", {31'd0, rom_rd}, 32'd0);
                check("reset_addr", {14'd0, rom_addr}, 32'd0);
                check("reset_col", {31'd0, collision}, 32'd0);
            end else begin
                e   = edge_cnt;
                got = 1'b0;
                if (sb.size() > 0 && sb[0].due == e) begin
                    it  = sb.pop_front();
                    got = 1'b1;
                end else if (sb.size() > 0 && sb[0].due < e) begin
                    it = sb.pop_front();
                    check("sb_order", it.due, e);
                end
                ergb = got ? it.rgb : 24'h000000;
                evld = got ? it.vld : 1'b0;
                if (got && it.cset)              exp_col = 1'b1;
                else if (fs_at.exists(e) && fs_at[e]) exp_col = 1'b0;
                check("rgb", {8'd0, Red, Green, Blue}, {8'd0, ergb});
                check("pix_valid", {31'd0, pix_valid}, {31'd0, evld});
                check("collision", {31'd0, collision}, {31'd0, exp_col});
                check("rom_rd", {31'd0, rom_rd}, {31'd0, exp_rd.exists(e) ? exp_rd[e] : 1'b0});
                check("rom_addr", {14'd0, rom_addr},
                      {14'd0, exp_addr.exists(e) ? exp_addr[e] : 18'd0});
                if (exp_rd.exists(e))   exp_rd.delete(e);
                if (exp_addr.exists(e)) exp_addr.delete(e);
                if (fs_at.exists(e))    fs_at.delete(e);
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            int r;
            r = $urandom_range(0, 7);
            if (r > 3) r = $urandom_range(4, 15);
            rom_mem[i] = 4'(r);
        end
        rom_mem[36] = 4'd1;   // addr 100
        rom_mem[8]  = 4'd3;   // addr 200
        rom_mem[44] = 4'd2;   // addr 300
        rom_mem[16] = 4'd0;   // addr 400
        rom_mem[52] = 4'd2;   // addr 500

        #1;
        Reset_n = 1'b0;
        started = 1'b1;
        do_reset(3);

        // Idle, visible: background, no ROM access.
        repeat (5) step(4'b0000, 18'd0, 18'd0, 18'd0, 18'd0, 1'b1, 1'b0);
        // Priority: layer 1 beats layer 2.
        repeat (3) step(4'b0110, 18'd7, 18'd100, 18'd200, 18'd9, 1'b1, 1'b0);
        step(4'b0100, 18'd7, 18'd100, 18'd200, 18'd9, 1'b1, 1'b0);
        // Runner overlapping an obstacle with an opaque pixel.
        repeat (2) step(4'b0011, 18'd300, 18'd200, 18'd0, 18'd0, 1'b1, 1'b0);
        repeat (4) step(4'b0001, 18'd300, 18'd0, 18'd0, 18'd0, 1'b1, 1'b0);
        step(4'b0000, 18'd0, 18'd0, 18'd0, 18'd0, 1'b1, 1'b1);
        repeat (4) step(4'b0000, 18'd0, 18'd0, 18'd0, 18'd0, 1'b1, 1'b0);
        // Overlap on a transparent runner pixel.
        repeat (3) step(4'b0011, 18'd400, 18'd200, 18'd0, 18'd0, 1'b1, 1'b0);
        repeat (4) step(4'b0000, 18'd0, 18'd0, 18'd0, 18'd0, 1'b1, 1'b0);
        step(4'b0000, 18'd0, 18'd0, 18'd0, 18'd0, 1'b1, 1'b1);
        // Blanking window.
        repeat (2) step(4'b0010, 18'd0, 18'd500, 18'd0, 18'd0, 1'b1, 1'b0);
        repeat (5) step(4'b0010, 18'd0, 18'd500, 18'd0, 18'd0, 1'b0, 1'b0);
        repeat (3) step(4'b0010, 18'd0, 18'd500, 18'd0, 18'd0, 1'b1, 1'b0);
        // Set and frame_start in the same cycle: set must win.
        repeat (2) step(4'b0011, 18'd300, 18'd200, 18'd0, 18'd0, 1'b1, 1'b0);
        step(4'b0000, 18'd0, 18'd0, 18'd0, 18'd0, 1'b1, 1'b0);
        step(4'b0000, 18'd0, 18'd0, 18'd0, 18'd0, 1'b1, 1'b1);
        repeat (3) step(4'b0000, 18'd0, 18'd0, 18'd0, 18'd0, 1'b1, 1'b0);
        // Mid-stream reset with pixels in flight.
        repeat (3) step(4'b0011, 18'd300, 18'd100, 18'd0, 18'd0, 1'b1, 1'b0);
        do_reset(1);
        repeat (5) step(4'b0010, 18'd0, 18'd100, 18'd0, 18'd0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  on;
            logic [17:0] a0, a1, a2, a3;
            on = 4'($urandom);
            if ($urandom_range(0, 3) == 0) on = 4'b0000;
            a0 = 18'($urandom); a1 = 18'($urandom);
            a2 = 18'($urandom); a3 = 18'($urandom);
            step(on, a0, a1, a2, a3, ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 29) == 0));
            if (n == 200) do_reset(2);
        end
        repeat (5) step(4'b0000, 18'd0, 18'd0, 18'd0, 18'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
